// File: rtl/mesm6_irq_pkg.sv
// Shared constants for the MESM-6 interrupt front end: line count and
// register map of the configuration bus.
package mesm6_irq_pkg;

    localparam int NIRQ = 48;

    typedef enum logic [2:0] {
        IRQ_RAW  = 3'o0,
        IRQ_MODE = 3'o1,
        IRQ_POL  = 3'o2,
        IRQ_STAT = 3'o3
    } irq_reg_e;

endpackage

// File: rtl/mesm6_irq_line.sv
// One interrupt line: 2-flop synchronizer, polarity, glitch filter and
// level/edge output stage.
module mesm6_irq_line #(
    parameter int FILTER = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic dev_irq,
    input  logic mode,
    input  logic pol,
    output logic raw,
    output logic filt,
    output logic pic_irq
);

    localparam int              CW   = $clog2(FILTER) + 1;
    localparam logic [CW-1:0]   LAST = CW'(FILTER - 1);

    logic          s1, s2, filt_d;
    logic [CW-1:0] cnt;
    logic          a;

    assign a   = s2 ^ pol;
    assign raw = s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            filt    <= 1'b0;
            filt_d  <= 1'b0;
            cnt     <= '0;
            pic_irq <= 1'b0;
        end else begin
            s1     <= dev_irq;
            s2     <= s1;
            filt_d <= filt;
            // The count only runs while the line disagrees with the accepted
            // value, so any bounce back restarts qualification from zero.
            if (a != filt) begin
                if (cnt == LAST) begin
                    filt <= a;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            pic_irq <= mode ? (filt & ~filt_d) : filt;
        end
    end

endmodule

// File: rtl/mesm6_irq_sync.sv
// Interrupt front end for the MESM-6 controller: per-line filtering plus
// the MODE/POL configuration registers and read-back mux.
module mesm6_irq_sync
    import mesm6_irq_pkg::*;
#(
    parameter int FILTER = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] dev_irq,
    output logic [NIRQ-1:0] pic_irq,
    input  logic [14:0]     irq_addr,
    input  logic            irq_read,
    input  logic            irq_write,
    output logic [NIRQ-1:0] irq_rdata,
    input  logic [NIRQ-1:0] irq_wdata,
    output logic            irq_done
);

    logic [NIRQ-1:0] mode, pol, raw, stat;
    logic            unused_addr;

    // Only the low address bits select a register.
    assign unused_addr = |irq_addr[14:3];

    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= '0;
            pol      <= '0;
            irq_done <= 1'b0;
        end else begin
            irq_done <= irq_read | irq_write;
            if (irq_write) begin
                case (irq_addr[2:0])
                    IRQ_MODE: mode <= irq_wdata;
                    IRQ_POL:  pol  <= irq_wdata;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        irq_rdata = '0;
        case (irq_addr[2:0])
            IRQ_RAW:  irq_rdata = raw;
            IRQ_MODE: irq_rdata = mode;
            IRQ_POL:  irq_rdata = pol;
            IRQ_STAT: irq_rdata = stat;
            default:  irq_rdata = '0;
        endcase
    end

    for (genvar i = 0; i < NIRQ; i++) begin : g_line
        mesm6_irq_line #(.FILTER(FILTER)) u_line (
            .clk     (clk),
            .reset   (reset),
            .dev_irq (dev_irq[i]),
            .mode    (mode[i]),
            .pol     (pol[i]),
            .raw     (raw[i]),
            .filt    (stat[i]),
            .pic_irq (pic_irq[i])
        );
    end

endmodule

// File: tb/tb_mesm6_irq_sync.sv
// Bench for mesm6_irq_sync: directed scenarios plus randomized traffic
// against a run-length reference model of the filter.
module tb_mesm6_irq_sync;

    localparam int FILTER = 2;
    localparam int N      = 48;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  dev_irq = '0;
    logic [N-1:0]  pic_irq;
    logic [14:0]   irq_addr = '0;
    logic          irq_read = 1'b0;
    logic          irq_write = 1'b0;
    logic [N-1:0]  irq_rdata;
    logic [N-1:0]  irq_wdata = '0;
    logic          irq_done;

    int checks = 0;
    int errors = 0;

    mesm6_irq_sync #(.FILTER(FILTER)) dut (
        .clk       (clk),
        .reset     (reset),
        .dev_irq   (dev_irq),
        .pic_irq   (pic_irq),
        .irq_addr  (irq_addr),
        .irq_read  (irq_read),
        .irq_write (irq_write),
        .irq_rdata (irq_rdata),
        .irq_wdata (irq_wdata),
        .irq_done  (irq_done)
    );

    always #5 clk = ~clk;

    // Reference model: a line's accepted value changes once its polarity-
    // corrected synchronized sample has held a new value for FILTER samples.
    logic [N-1:0] m_s1, m_s2, m_filt, m_filt_d, m_pic, m_mode, m_pol;
    logic         m_done;
    int           run_len [N];
    logic         run_val [N];

    function automatic logic [N-1:0] exp_rdata(input logic [2:0] a);
        case (a)
            3'o0:    return m_s2;
            3'o1:    return m_mode;
            3'o2:    return m_pol;
            3'o3:    return m_filt;
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        logic [N-1:0] din, a, wd;
        logic         rs, wr, rd;
        logic [2:0]   ad;
        din = dev_irq; rs = reset; wr = irq_write; rd = irq_read;
        ad = irq_addr[2:0]; wd = irq_wdata;
        a = m_s2 ^ m_pol;
        @(posedge clk);
        if (rs) begin
            m_s1 = '0; m_s2 = '0; m_filt = '0; m_filt_d = '0; m_pic = '0;
            m_mode = '0; m_pol = '0; m_done = 1'b0;
            for (int i = 0; i < N; i++) begin run_len[i] = 0; run_val[i] = 1'b0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (run_len[i] > 0 && run_val[i] == a[i]) begin
                    if (run_len[i] < FILTER) run_len[i]++;
                end else begin
                    run_val[i] = a[i];
                    run_len[i] = 1;
                end
            end
            m_pic    = (m_mode & m_filt & ~m_filt_d) | (~m_mode & m_filt);
            m_filt_d = m_filt;
            for (int i = 0; i < N; i++)
                if (run_len[i] >= FILTER && run_val[i] != m_filt[i]) m_filt[i] = run_val[i];
            m_s2 = m_s1;
            m_s1 = din;
            if (wr && ad == 3'o1) m_mode = wd;
            if (wr && ad == 3'o2) m_pol = wd;
            m_done = rd | wr;
        end
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [N-1:0] d);
        irq_addr = {12'h0, a}; irq_wdata = d; irq_write = 1'b1;
        tick();
        irq_write = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        settle(2);
        reset = 1'b0;
        checks++;
        if (pic_irq !== '0) begin errors++; $display("FAIL reset_pic got %h exp 0", pic_irq); end
        checks++;
        if (irq_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", irq_done); end
        for (int r = 0; r < 4; r++) begin
            irq_addr = 15'(r); #1;
            checks++;
            if (irq_rdata !== '0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", r, irq_rdata); end
        end
    endtask

    task automatic test_level();
        dev_irq[5] = 1'b1;
        irq_addr = 15'o3;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (pic_irq[5] !== (k >= 5)) begin
                errors++; $display("FAIL level_pic5 edge %0d got %b exp %b", k, pic_irq[5], k >= 5);
            end
        end
        checks++;
        if (irq_rdata !== 48'h20) begin errors++; $display("FAIL level_stat got %h exp 20", irq_rdata); end
        dev_irq[5] = 1'b0;
        settle(6);
        checks++;
        if (pic_irq !== '0) begin errors++; $display("FAIL level_release got %h exp 0", pic_irq); end
    endtask

    task automatic test_edge();
        int hi, first;
        bus_write(3'o1, 48'h1);
        checks++;
        if (irq_done !== 1'b1) begin errors++; $display("FAIL edge_wr_done got %b exp 1", irq_done); end
        dev_irq[0] = 1'b1;
        hi = 0; first = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pic_irq[0]) begin hi++; if (first < 0) first = k; end
        end
        checks++;
        if (hi != 1 || first != 5) begin
            errors++; $display("FAIL edge_rise pulses %0d at %0d exp 1 at 5", hi, first);
        end
        dev_irq[0] = 1'b0;
        hi = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (pic_irq[0]) hi++;
        end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL edge_fall pulses %0d exp 0", hi); end
        bus_write(3'o1, 48'h0);
    endtask

    task automatic test_glitch();
        logic [15:0] pat;
        pat = 16'b1111_1110_1010_0001;
        for (int t = 0; t < 16; t++) begin
            dev_irq[47] = pat[t];
            tick();
            checks++;
            if (pic_irq[47] !== (t + 1 >= 14) || pic_irq !== m_pic) begin
                errors++;
                $display("FAIL glitch_pic47 edge %0d got %h exp bit47=%b model %h",
                         t + 1, pic_irq, t + 1 >= 14, m_pic);
            end
        end
        dev_irq[47] = 1'b0;
        settle(6);
    endtask

    task automatic test_pol();
        bus_write(3'o2, 48'h2);
        checks++;
        if (pic_irq[1] !== 1'b0) begin errors++; $display("FAIL pol_w got %b exp 0", pic_irq[1]); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (pic_irq[1] !== (k >= 3)) begin
                errors++; $display("FAIL pol_pic1 edge %0d got %b exp %b", k, pic_irq[1], k >= 3);
            end
        end
        irq_addr = 15'o0; #1;
        checks++;
        if (irq_rdata[1] !== 1'b0) begin errors++; $display("FAIL pol_raw1 got %b exp 0", irq_rdata[1]); end
        irq_addr = 15'o3; #1;
        checks++;
        if (irq_rdata !== 48'h2) begin errors++; $display("FAIL pol_stat got %h exp 2", irq_rdata); end
        bus_write(3'o2, 48'h0);
        settle(6);
    endtask

    task automatic test_reset_midqual();
        bus_write(3'o1, 48'h0f0);
        bus_write(3'o2, 48'hff00_0000_0000);
        dev_irq[3] = 1'b1;
        settle(6);
        checks++;
        if (pic_irq === '0) begin errors++; $display("FAIL rq_pre got %h exp nonzero", pic_irq); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (pic_irq !== '0 || irq_done !== 1'b0) begin
            errors++; $display("FAIL rq_outs pic %h done %b exp 0 0", pic_irq, irq_done);
        end
        irq_addr = 15'o1; #1;
        checks++;
        if (irq_rdata !== '0) begin errors++; $display("FAIL rq_mode got %h exp 0", irq_rdata); end
        irq_addr = 15'o2; #1;
        checks++;
        if (irq_rdata !== '0) begin errors++; $display("FAIL rq_pol got %h exp 0", irq_rdata); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (pic_irq[3] !== (k >= 5)) begin
                errors++; $display("FAIL rq_pic3 edge %0d got %b exp %b", k, pic_irq[3], k >= 5);
            end
        end
        dev_irq[3] = 1'b0;
        settle(6);
    endtask

    task automatic test_back_to_back();
        bus_write(3'o5, '1);
        irq_addr = 15'o5; irq_read = 1'b1; #1;
        checks++;
        if (irq_rdata !== '0) begin errors++; $display("FAIL bus_o5 got %h exp 0", irq_rdata); end
        tick();
        checks++;
        if (irq_done !== 1'b1) begin errors++; $display("FAIL bus_rd_done got %b exp 1", irq_done); end
        irq_read = 1'b0;
        bus_write(3'o1, 48'h8000_0000_0001);
        checks++;
        if (irq_done !== 1'b1) begin errors++; $display("FAIL bus_wr_done got %b exp 1", irq_done); end
        irq_addr = 15'o1; irq_read = 1'b1; irq_write = 1'b1; irq_wdata = 48'h0000_0000_0300;
        tick();
        irq_read = 1'b0; irq_write = 1'b0;
        checks++;
        if (irq_done !== 1'b1 || irq_rdata !== 48'h300) begin
            errors++; $display("FAIL bus_rw done %b mode %h exp 1 300", irq_done, irq_rdata);
        end
        tick();
        checks++;
        if (irq_done !== 1'b0) begin errors++; $display("FAIL bus_idle_done got %b exp 0", irq_done); end
        bus_write(3'o1, 48'h0);
    endtask

    task automatic test_random();
        logic [63:0] m1, m2;
        int r;
        for (int c = 0; c < 400; c++) begin
            m1 = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            m2 = {$urandom, $urandom};
            dev_irq   = dev_irq ^ m1[N-1:0];
            r         = $urandom_range(0, 15);
            irq_write = (r == 0);
            irq_read  = (r == 1 || r == 2);
            irq_addr  = 15'($urandom_range(0, 32767));
            if (irq_write && $urandom_range(0, 1) == 1) irq_addr[2:0] = ($urandom_range(0, 1) == 1) ? 3'o1 : 3'o2;
            irq_wdata = m2[N-1:0];
            reset     = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (pic_irq !== m_pic) begin
                errors++; $display("FAIL rnd_pic cyc %0d got %h exp %h", c, pic_irq, m_pic);
            end
            checks++;
            if (irq_done !== m_done) begin
                errors++; $display("FAIL rnd_done cyc %0d got %b exp %b", c, irq_done, m_done);
            end
            checks++;
            if (irq_rdata !== exp_rdata(irq_addr[2:0])) begin
                errors++; $display("FAIL rnd_rdata cyc %0d addr %0o got %h exp %h",
                                   c, irq_addr[2:0], irq_rdata, exp_rdata(irq_addr[2:0]));
            end
        end
        reset = 1'b0; irq_read = 1'b0; irq_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_glitch();
        test_pol();
        test_reset_midqual();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
